// File: rtl/imuldiv_div_arbiter.sv
// imuldiv_div_arbiter: shares one iterative divider between two requesters, with per-requester completion counters.
// Define IMULDIV_DIV_ARB_ROUND_ROBIN_EN for round-robin contention; the default is requester-0 fixed priority.
module imuldiv_div_arbiter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_msg_fn,
  input  logic [31:0]      req0_msg_a,
  input  logic [31:0]      req0_msg_b,
  input  logic             req0_val,
  output logic             req0_rdy,
  input  logic             req1_msg_fn,
  input  logic [31:0]      req1_msg_a,
  input  logic [31:0]      req1_msg_b,
  input  logic             req1_val,
  output logic             req1_rdy,
  output logic [63:0]      resp0_msg_result,
  output logic             resp0_val,
  input  logic             resp0_rdy,
  output logic [63:0]      resp1_msg_result,
  output logic             resp1_val,
  input  logic             resp1_rdy,
  output logic             divreq_msg_fn,
  output logic [31:0]      divreq_msg_a,
  output logic [31:0]      divreq_msg_b,
  output logic             divreq_val,
  input  logic             divreq_rdy,
  input  logic [63:0]      divresp_msg_result,
  input  logic             divresp_val,
  output logic             divresp_rdy,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic             busy
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t state;
  logic   owner;
  logic   win;
  logic   any_val;
  logic   req_fire;
  logic   resp_fire;
`ifdef IMULDIV_DIV_ARB_ROUND_ROBIN_EN
  logic   last_grant;
`endif

  assign any_val   = req0_val | req1_val;
  assign req_fire  = (state == IDLE) & any_val & divreq_rdy;
  assign resp_fire = (state == BUSY) & divresp_val & divresp_rdy;

  // Winner among valid requesters; with none valid it defaults to requester 0.
  always_comb begin
    win = 1'b0;
`ifdef IMULDIV_DIV_ARB_ROUND_ROBIN_EN
    if (req0_val && req1_val) win = ~last_grant;
    else                      win = req1_val;
`else
    win = ~req0_val & req1_val;
`endif
  end

  // Zero-latency request/response steering; messages pass straight through.
  always_comb begin
    divreq_val    = 1'b0;
    req0_rdy      = 1'b0;
    req1_rdy      = 1'b0;
    resp0_val     = 1'b0;
    resp1_val     = 1'b0;
    divresp_rdy   = 1'b0;
    divreq_msg_fn = win ? req1_msg_fn : req0_msg_fn;
    divreq_msg_a  = win ? req1_msg_a  : req0_msg_a;
    divreq_msg_b  = win ? req1_msg_b  : req0_msg_b;
    if (state == IDLE) begin
      divreq_val = any_val;
      req0_rdy   = any_val & ~win & divreq_rdy;
      req1_rdy   = any_val &  win & divreq_rdy;
    end else begin
      resp0_val   = divresp_val & ~owner;
      resp1_val   = divresp_val &  owner;
      divresp_rdy = owner ? resp1_rdy : resp0_rdy;
    end
  end

  assign resp0_msg_result = divresp_msg_result;
  assign resp1_msg_result = divresp_msg_result;

  // State, ownership and saturating completion counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      owner <= 1'b0;
      busy  <= 1'b0;
      cnt0  <= '0;
      cnt1  <= '0;
`ifdef IMULDIV_DIV_ARB_ROUND_ROBIN_EN
      last_grant <= 1'b1;
`endif
    end else begin
      if (req_fire) begin
        state <= BUSY;
        owner <= win;
        busy  <= 1'b1;
      end
      if (resp_fire) begin
        state <= IDLE;
        busy  <= 1'b0;
        if (!owner && cnt0 != CNT_MAX) cnt0 <= cnt0 + CNT_W'(1);
        if (owner && cnt1 != CNT_MAX)  cnt1 <= cnt1 + CNT_W'(1);
`ifdef IMULDIV_DIV_ARB_ROUND_ROBIN_EN
        last_grant <= owner;
`endif
      end
    end
  end

endmodule

// File: tb/tb_imuldiv_div_arbiter.sv
// Self-checking bench for imuldiv_div_arbiter: the bench plays both requesters and the shared divider.
// A second instance with 2-bit counters is driven in parallel to observe saturation.
module tb_imuldiv_div_arbiter;
  logic clk;
  logic reset;
  logic req0_msg_fn, req1_msg_fn;
  logic [31:0] req0_msg_a, req0_msg_b, req1_msg_a, req1_msg_b;
  logic req0_val, req1_val, req0_rdy, req1_rdy;
  logic [63:0] resp0_msg_result, resp1_msg_result;
  logic resp0_val, resp1_val, resp0_rdy, resp1_rdy;
  logic divreq_msg_fn;
  logic [31:0] divreq_msg_a, divreq_msg_b;
  logic divreq_val, divreq_rdy;
  logic [63:0] divresp_msg_result;
  logic divresp_val, divresp_rdy;
  logic [15:0] cnt0, cnt1;
  logic busy;

  logic s_req0_rdy, s_req1_rdy, s_resp0_val, s_resp1_val, s_divreq_val, s_divresp_rdy, s_busy;
  logic [63:0] s_resp0_msg_result, s_resp1_msg_result;
  logic s_divreq_msg_fn;
  logic [31:0] s_divreq_msg_a, s_divreq_msg_b;
  logic [1:0] s_cnt0, s_cnt1;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic m_busy, m_owner, m_last;
  int   m_cnt[2];

  imuldiv_div_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_msg_fn(req0_msg_fn), .req0_msg_a(req0_msg_a), .req0_msg_b(req0_msg_b),
    .req0_val(req0_val), .req0_rdy(req0_rdy),
    .req1_msg_fn(req1_msg_fn), .req1_msg_a(req1_msg_a), .req1_msg_b(req1_msg_b),
    .req1_val(req1_val), .req1_rdy(req1_rdy),
    .resp0_msg_result(resp0_msg_result), .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
    .resp1_msg_result(resp1_msg_result), .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
    .divreq_msg_fn(divreq_msg_fn), .divreq_msg_a(divreq_msg_a), .divreq_msg_b(divreq_msg_b),
    .divreq_val(divreq_val), .divreq_rdy(divreq_rdy),
    .divresp_msg_result(divresp_msg_result), .divresp_val(divresp_val), .divresp_rdy(divresp_rdy),
    .cnt0(cnt0), .cnt1(cnt1), .busy(busy)
  );

  imuldiv_div_arbiter #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset),
    .req0_msg_fn(req0_msg_fn), .req0_msg_a(req0_msg_a), .req0_msg_b(req0_msg_b),
    .req0_val(req0_val), .req0_rdy(s_req0_rdy),
    .req1_msg_fn(req1_msg_fn), .req1_msg_a(req1_msg_a), .req1_msg_b(req1_msg_b),
    .req1_val(req1_val), .req1_rdy(s_req1_rdy),
    .resp0_msg_result(s_resp0_msg_result), .resp0_val(s_resp0_val), .resp0_rdy(resp0_rdy),
    .resp1_msg_result(s_resp1_msg_result), .resp1_val(s_resp1_val), .resp1_rdy(resp1_rdy),
    .divreq_msg_fn(s_divreq_msg_fn), .divreq_msg_a(s_divreq_msg_a), .divreq_msg_b(s_divreq_msg_b),
    .divreq_val(s_divreq_val), .divreq_rdy(divreq_rdy),
    .divresp_msg_result(divresp_msg_result), .divresp_val(divresp_val), .divresp_rdy(s_divresp_rdy),
    .cnt0(s_cnt0), .cnt1(s_cnt1), .busy(s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1);
  end

  // Quotient/remainder as a divider would produce them, packed {rem, quot}.
  function automatic logic [63:0] div_ref(input logic fn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (fn) begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  function automatic logic exp_win(input logic v0, input logic v1);
`ifdef IMULDIV_DIV_ARB_ROUND_ROBIN_EN
    if (v0 && v1) return !m_last;
`else
    if (v0 && v1) return 1'b0;
`endif
    return v1;
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_msg_fn = 1'b0; req0_msg_a = '0; req0_msg_b = '0; req0_val = 1'b0;
    req1_msg_fn = 1'b0; req1_msg_a = '0; req1_msg_b = '0; req1_val = 1'b0;
    resp0_rdy = 1'b0; resp1_rdy = 1'b0; divreq_rdy = 1'b0;
    divresp_msg_result = '0; divresp_val = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    m_busy = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_cnt[0] = 0; m_cnt[1] = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if ({busy, divreq_val, req0_rdy, req1_rdy, resp0_val, resp1_val, divresp_rdy} !== 7'b0) begin
      errors++; $display("FAIL reset_outputs: got %b required 0000000",
        {busy, divreq_val, req0_rdy, req1_rdy, resp0_val, resp1_val, divresp_rdy});
    end
    checks++;
    if (cnt0 !== 16'd0 || cnt1 !== 16'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d/%0d required 0/0", cnt0, cnt1);
    end
    tick();
    // Stray divider response while idle, no requester valid
    req0_msg_a = 32'h1234_5678; req0_msg_b = 32'h0000_0003; req0_msg_fn = 1'b1;
    req1_msg_a = 32'hCAFE_0001; req1_msg_b = 32'h0000_0009;
    divreq_rdy = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
    divresp_val = 1'b1; divresp_msg_result = 64'hDEAD_BEEF_0BAD_F00D;
    @(negedge clk);
    checks++;
    if ({divreq_val, req0_rdy, req1_rdy, resp0_val, resp1_val, divresp_rdy} !== 6'b0) begin
      errors++; $display("FAIL idle_ignore: got %b required 000000",
        {divreq_val, req0_rdy, req1_rdy, resp0_val, resp1_val, divresp_rdy});
    end
    checks++;
    if ({divreq_msg_fn, divreq_msg_a, divreq_msg_b} !== {1'b1, 32'h1234_5678, 32'h0000_0003}) begin
      errors++; $display("FAIL idle_msg_default: got %h/%h required 12345678/00000003", divreq_msg_a, divreq_msg_b);
    end
    tick();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cnt0 !== 16'd0 || cnt1 !== 16'd0) begin
      errors++; $display("FAIL idle_stray_state: busy=%b cnt=%0d/%0d required 0 0/0", busy, cnt0, cnt1);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_single_signed();
    apply_reset();
    req0_msg_fn = 1'b1; req0_msg_a = 32'hFFFF_FFF9; req0_msg_b = 32'd2; req0_val = 1'b1;
    divreq_rdy = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if ({divreq_val, req0_rdy, req1_rdy} !== 3'b110 ||
        {divreq_msg_fn, divreq_msg_a, divreq_msg_b} !== {1'b1, 32'hFFFF_FFF9, 32'd2}) begin
      errors++; $display("FAIL single_issue: hs=%b a=%h b=%h required 110 fffffff9 00000002",
        {divreq_val, req0_rdy, req1_rdy}, divreq_msg_a, divreq_msg_b);
    end
    tick();
    req0_val = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || {divreq_val, resp0_val, resp1_val} !== 3'b000) begin
        errors++; $display("FAIL single_wait: busy=%b hs=%b required 1 000", busy, {divreq_val, resp0_val, resp1_val});
      end
      tick();
    end
    divresp_val = 1'b1; divresp_msg_result = 64'hFFFF_FFFF_FFFF_FFFD;
    @(negedge clk);
    checks++;
    if ({resp0_val, resp1_val, divresp_rdy} !== 3'b101 || resp0_msg_result !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      errors++; $display("FAIL single_resp: hs=%b res=%h required 101 ffffffff_fffffffd",
        {resp0_val, resp1_val, divresp_rdy}, resp0_msg_result);
    end
    tick();
    divresp_val = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cnt0 !== 16'd1 || cnt1 !== 16'd0) begin
      errors++; $display("FAIL single_cnt: busy=%b cnt=%0d/%0d required 0 1/0", busy, cnt0, cnt1);
    end
    tick();
  endtask

  task automatic test_contention();
    apply_reset();
    req0_msg_a = 32'd100; req0_msg_b = 32'd7; req0_val = 1'b1;
    req1_msg_a = 32'd9;   req1_msg_b = 32'd4; req1_val = 1'b1;
    divreq_rdy = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if ({req0_rdy, req1_rdy} !== 2'b10 || divreq_msg_a !== 32'd100 || divreq_msg_b !== 32'd7) begin
      errors++; $display("FAIL contend_first: rdy=%b a=%0d required 10 100", {req0_rdy, req1_rdy}, divreq_msg_a);
    end
    tick();
    req0_val = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || {divreq_val, req1_rdy} !== 2'b00) begin
      errors++; $display("FAIL contend_busy_block: busy=%b hs=%b required 1 00", busy, {divreq_val, req1_rdy});
    end
    tick();
    divresp_val = 1'b1; divresp_msg_result = 64'h0000_0002_0000_000E;
    @(negedge clk);
    checks++;
    if ({resp0_val, resp1_val, req1_rdy} !== 3'b100 || resp0_msg_result !== 64'h0000_0002_0000_000E) begin
      errors++; $display("FAIL contend_resp0: hs=%b res=%h required 100 00000002_0000000e",
        {resp0_val, resp1_val, req1_rdy}, resp0_msg_result);
    end
    tick();
    divresp_val = 1'b0;
    @(negedge clk);
    checks++;
    if ({req0_rdy, req1_rdy} !== 2'b01 || divreq_msg_a !== 32'd9 || divreq_msg_b !== 32'd4) begin
      errors++; $display("FAIL contend_second: rdy=%b a=%0d required 01 9", {req0_rdy, req1_rdy}, divreq_msg_a);
    end
    tick();
    req1_val = 1'b0;
    divresp_val = 1'b1; divresp_msg_result = 64'h0000_0001_0000_0002;
    @(negedge clk);
    checks++;
    if ({resp0_val, resp1_val} !== 2'b01 || resp1_msg_result !== 64'h0000_0001_0000_0002) begin
      errors++; $display("FAIL contend_resp1: hs=%b res=%h required 01 00000001_00000002",
        {resp0_val, resp1_val}, resp1_msg_result);
    end
    tick();
    divresp_val = 1'b0;
    @(negedge clk);
    checks++;
    if (cnt0 !== 16'd1 || cnt1 !== 16'd1) begin
      errors++; $display("FAIL contend_cnt: got %0d/%0d required 1/1", cnt0, cnt1);
    end
    tick();
  endtask

  task automatic test_priority();
    logic w;
    apply_reset();
    req0_val = 1'b1; req1_val = 1'b1; divreq_rdy = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
    for (int op = 0; op < 4; op++) begin
      req0_msg_a = $urandom; req0_msg_b = 32'($urandom_range(1, 1000));
      req1_msg_a = $urandom; req1_msg_b = 32'($urandom_range(1, 1000));
      w = exp_win(1'b1, 1'b1);
      @(negedge clk);
      checks++;
      if ({req0_rdy, req1_rdy} !== {!w, w}) begin
        errors++; $display("FAIL priority_grant op%0d: rdy=%b required %b", op, {req0_rdy, req1_rdy}, {!w, w});
      end
      tick();
      divresp_val = 1'b1; divresp_msg_result = {$urandom, $urandom};
      @(negedge clk);
      checks++;
      if ({resp0_val, resp1_val} !== {!w, w}) begin
        errors++; $display("FAIL priority_route op%0d: val=%b required %b", op, {resp0_val, resp1_val}, {!w, w});
      end
      tick();
      divresp_val = 1'b0;
      m_cnt[w]++; m_last = w;
    end
    @(negedge clk);
    checks++;
    if (cnt0 !== 16'(m_cnt[0]) || cnt1 !== 16'(m_cnt[1])) begin
      errors++; $display("FAIL priority_cnt: got %0d/%0d required %0d/%0d", cnt0, cnt1, m_cnt[0], m_cnt[1]);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_backpressure();
    apply_reset();
    req1_msg_a = 32'd77; req1_msg_b = 32'd5; req1_val = 1'b1; divreq_rdy = 1'b1;
    tick();
    req1_val = 1'b0;
    req0_val = 1'b1; req0_msg_a = 32'd8; req0_msg_b = 32'd2;
    divresp_val = 1'b1; divresp_msg_result = 64'h0000_0002_0000_000F;
    resp0_rdy = 1'b1; resp1_rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || {divreq_val, req0_rdy, req1_rdy, resp0_val, resp1_val, divresp_rdy} !== 6'b000010) begin
        errors++; $display("FAIL backpressure_hold cyc%0d: busy=%b hs=%b required 1 000010", i, busy,
          {divreq_val, req0_rdy, req1_rdy, resp0_val, resp1_val, divresp_rdy});
      end
      tick();
    end
    resp1_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (divresp_rdy !== 1'b1 || resp1_val !== 1'b1 || resp1_msg_result !== 64'h0000_0002_0000_000F) begin
      errors++; $display("FAIL backpressure_release: rdy=%b val=%b res=%h required 1 1 00000002_0000000f",
        divresp_rdy, resp1_val, resp1_msg_result);
    end
    tick();
    divresp_val = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cnt1 !== 16'd1 || cnt0 !== 16'd0 || req0_rdy !== 1'b1) begin
      errors++; $display("FAIL backpressure_after: busy=%b cnt=%0d/%0d req0_rdy=%b required 0 0/1 1",
        busy, cnt0, cnt1, req0_rdy);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req0_msg_a = 32'd20; req0_msg_b = 32'd3; req0_val = 1'b1; divreq_rdy = 1'b1; resp0_rdy = 1'b1;
    tick();
    req0_val = 1'b0; divresp_val = 1'b1; divresp_msg_result = 64'h0000_0002_0000_0006;
    tick();
    divresp_val = 1'b0;
    req0_val = 1'b1;
    tick();
    req0_val = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    divresp_val = 1'b1; divresp_msg_result = 64'hBAD0_BAD0_BAD0_BAD0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cnt0 !== 16'd0 || cnt1 !== 16'd0 || {resp0_val, resp1_val, divresp_rdy} !== 3'b000) begin
      errors++; $display("FAIL reset_mid: busy=%b cnt=%0d/%0d hs=%b required 0 0/0 000",
        busy, cnt0, cnt1, {resp0_val, resp1_val, divresp_rdy});
    end
    tick();
    divresp_val = 1'b0;
    req0_msg_a = 32'd50; req0_msg_b = 32'd5; req0_val = 1'b1;
    @(negedge clk);
    checks++;
    if (req0_rdy !== 1'b1 || divreq_msg_a !== 32'd50) begin
      errors++; $display("FAIL reset_mid_reissue: rdy=%b a=%0d required 1 50", req0_rdy, divreq_msg_a);
    end
    tick();
    req0_val = 1'b0; divresp_val = 1'b1; divresp_msg_result = 64'h0000_0000_0000_000A;
    @(negedge clk);
    checks++;
    if (resp0_val !== 1'b1 || resp0_msg_result !== 64'h0000_0000_0000_000A) begin
      errors++; $display("FAIL reset_mid_resp: val=%b res=%h required 1 00000000_0000000a", resp0_val, resp0_msg_result);
    end
    tick();
    divresp_val = 1'b0;
    @(negedge clk);
    checks++;
    if (cnt0 !== 16'd1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid_cnt: cnt0=%0d busy=%b required 1 0", cnt0, busy);
    end
    tick();
  endtask

  task automatic test_saturation();
    int exp_s[5] = '{1, 2, 3, 3, 3};
    apply_reset();
    divreq_rdy = 1'b1; resp0_rdy = 1'b1;
    for (int op = 0; op < 5; op++) begin
      req0_msg_a = $urandom; req0_msg_b = 32'($urandom_range(1, 50)); req0_val = 1'b1;
      tick();
      req0_val = 1'b0; divresp_val = 1'b1; divresp_msg_result = {$urandom, $urandom};
      tick();
      divresp_val = 1'b0;
      @(negedge clk);
      checks++;
      if (s_cnt0 !== 2'(exp_s[op]) || cnt0 !== 16'(op + 1)) begin
        errors++; $display("FAIL saturation op%0d: cnt_w2=%0d cnt_w16=%0d required %0d %0d",
          op, s_cnt0, cnt0, exp_s[op], op + 1);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic pv[2], pfn[2];
    logic [31:0] pa[2], pb[2];
    logic [63:0] exp_res;
    logic [5:0] exp_hs;
    logic w, v0, v1, own_rdy;
    int lat;
    apply_reset();
    exp_res = '0; lat = 0;
    for (int n = 0; n < 2; n++) begin pv[n] = 1'b0; pfn[n] = 1'b0; pa[n] = '0; pb[n] = 32'd1; end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int n = 0; n < 2; n++) begin
        if (!pv[n] && $urandom_range(0, 3) == 0) begin
          pv[n] = 1'b1;
          pfn[n] = 1'($urandom_range(0, 1));
          pa[n] = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 500)) : $urandom;
          pb[n] = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
          if (pb[n] == 32'd0) pb[n] = 32'd1;
          if (pfn[n] && pa[n] == 32'h8000_0000 && pb[n] == 32'hFFFF_FFFF) pb[n] = 32'd1;
        end
      end
      req0_val = pv[0]; req0_msg_fn = pfn[0]; req0_msg_a = pa[0]; req0_msg_b = pb[0];
      req1_val = pv[1]; req1_msg_fn = pfn[1]; req1_msg_a = pa[1]; req1_msg_b = pb[1];
      divreq_rdy = ($urandom_range(0, 3) != 0);
      resp0_rdy = ($urandom_range(0, 2) != 0);
      resp1_rdy = ($urandom_range(0, 2) != 0);
      if (m_busy) begin
        if (lat > 0) begin
          lat--; divresp_val = 1'b0; divresp_msg_result = {$urandom, $urandom};
        end else begin
          divresp_val = 1'b1; divresp_msg_result = exp_res;
        end
      end else begin
        divresp_val = ($urandom_range(0, 7) == 0);
        divresp_msg_result = {$urandom, $urandom};
      end
      @(negedge clk);
      v0 = pv[0]; v1 = pv[1];
      w = exp_win(v0, v1);
      own_rdy = m_owner ? resp1_rdy : resp0_rdy;
      if (!m_busy) exp_hs = {v0 | v1, (v0 | v1) & !w & divreq_rdy, (v0 | v1) & w & divreq_rdy, 3'b000};
      else         exp_hs = {3'b000, divresp_val & !m_owner, divresp_val & m_owner, own_rdy};
      checks++;
      if ({divreq_val, req0_rdy, req1_rdy, resp0_val, resp1_val, divresp_rdy} !== exp_hs) begin
        errors++; $display("FAIL rand_handshake cyc%0d: got %b required %b", cyc,
          {divreq_val, req0_rdy, req1_rdy, resp0_val, resp1_val, divresp_rdy}, exp_hs);
      end
      checks++;
      if ({s_divreq_val, s_req0_rdy, s_req1_rdy, s_resp0_val, s_resp1_val, s_divresp_rdy} !== exp_hs) begin
        errors++; $display("FAIL rand_handshake_w2 cyc%0d: got %b required %b", cyc,
          {s_divreq_val, s_req0_rdy, s_req1_rdy, s_resp0_val, s_resp1_val, s_divresp_rdy}, exp_hs);
      end
      if (!m_busy) begin
        checks++;
        if ({divreq_msg_fn, divreq_msg_a, divreq_msg_b} !== {pfn[w], pa[w], pb[w]} ||
            {s_divreq_msg_fn, s_divreq_msg_a, s_divreq_msg_b} !== {pfn[w], pa[w], pb[w]}) begin
          errors++; $display("FAIL rand_divreq_msg cyc%0d: got %b/%h/%h required %b/%h/%h", cyc,
            divreq_msg_fn, divreq_msg_a, divreq_msg_b, pfn[w], pa[w], pb[w]);
        end
      end else if (divresp_val) begin
        checks++;
        if (resp0_msg_result !== exp_res || resp1_msg_result !== exp_res ||
            s_resp0_msg_result !== exp_res || s_resp1_msg_result !== exp_res) begin
          errors++; $display("FAIL rand_resp_msg cyc%0d: got %h/%h required %h", cyc,
            resp0_msg_result, resp1_msg_result, exp_res);
        end
      end
      checks++;
      if (busy !== m_busy || s_busy !== m_busy) begin
        errors++; $display("FAIL rand_busy cyc%0d: got %b/%b required %b", cyc, busy, s_busy, m_busy);
      end
      checks++;
      if (cnt0 !== 16'(sat(m_cnt[0], 65535)) || cnt1 !== 16'(sat(m_cnt[1], 65535)) ||
          s_cnt0 !== 2'(sat(m_cnt[0], 3)) || s_cnt1 !== 2'(sat(m_cnt[1], 3))) begin
        errors++; $display("FAIL rand_cnt cyc%0d: got %0d/%0d w2 %0d/%0d required %0d/%0d", cyc,
          cnt0, cnt1, s_cnt0, s_cnt1, m_cnt[0], m_cnt[1]);
      end
      if (!m_busy && (v0 | v1) && divreq_rdy) begin
        m_busy = 1'b1; m_owner = w;
        exp_res = div_ref(pfn[w], pa[w], pb[w]);
        pv[w] = 1'b0;
        lat = $urandom_range(0, 4);
      end else if (m_busy && divresp_val && own_rdy) begin
        m_busy = 1'b0;
        m_cnt[m_owner]++;
        m_last = m_owner;
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_signed();
    test_contention();
    test_priority();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
